// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the MEM-stage controller: FSM state encodings and
// the width of the WAIT-state cycle counter.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  // Plain constants so the FSM register stays an ordinary logic vector
  localparam logic [1:0] S_IDLE = ST_IDLE;
  localparam logic [1:0] S_REQ  = ST_REQ;
  localparam logic [1:0] S_WAIT = ST_WAIT;
  localparam logic [1:0] S_RESP = ST_RESP;

  localparam int TIMEOUT_DEFAULT = 64;

  // Counter must hold values 0..TIMEOUT-1; never narrower than one bit
  function automatic int cnt_width(input int timeout);
    return (timeout > 2) ? $clog2(timeout) : 1;
  endfunction

  localparam int WAIT_CNT_W_DEFAULT = cnt_width(TIMEOUT_DEFAULT);

endpackage

// File: rtl/mem_stage_ctrl_if.sv
// Request/response bus between the MEM-stage controller (master) and the
// multi-cycle data memory (slave).
interface mem_stage_ctrl_if #(
  parameter int DW = 16,
  parameter int AW = 16
);

  logic          mem_en;
  logic          mem_wr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_stall;
  logic          mem_done;

  modport master (
    output mem_en, mem_wr, mem_addr, mem_wdata,
    input  mem_rdata, mem_stall, mem_done
  );

  modport slave (
    input  mem_en, mem_wr, mem_addr, mem_wdata,
    output mem_rdata, mem_stall, mem_done
  );

endinterface

// File: rtl/mem_stage_ctrl_wait_timer.sv
// mem_wait_timer: counts cycles spent waiting for the memory and flags when
// the count has reached TIMEOUT-1. The count saturates there until cleared.
import mem_ctrl_pkg::*;

module mem_wait_timer #(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = cnt_width(TIMEOUT);

  logic [CW-1:0] count;

  assign expired = (count == CW'(TIMEOUT - 1));

  // Clear while a request is being issued, count up while waiting, hold at expiry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: producer side of the MEM/WB register. Issues EX/MEM loads
// and stores to a stalling data memory, freezes the upstream pipeline while
// an access is outstanding, and presents one result per instruction.
// Optional build macro MEM_ALIGN_CHK_EN: reject odd-address loads/stores in
// IDLE with an err pulse instead of issuing them.
import mem_ctrl_pkg::*;

module mem_stage_ctrl #(
  parameter int DW      = 16,
  parameter int AW      = 16,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic          in_rd,
  input  logic          in_wr,
  input  logic [AW-1:0] in_addr,
  input  logic [DW-1:0] in_wdata,
  input  logic          flush,
  mem_stage_ctrl_if.master mem,
  output logic          stall_pipe,
  output logic          out_valid,
  output logic [DW-1:0] data_read,
  output logic [AW-1:0] address_o,
  output logic          err
);

  logic [1:0]    state;
  logic          wr_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic          killed;
  logic          pass_q;
  logic          align_err_q;
  logic          timer_expired;
  logic          mem_op;
  logic          misaligned;
  logic          issue;
  logic          timeout_hit;

  assign mem_op = in_valid && (in_rd || in_wr) && !flush;

`ifdef MEM_ALIGN_CHK_EN
  assign misaligned = in_addr[0];
`else
  assign misaligned = 1'b0;
`endif

  assign issue       = (state == S_IDLE) && mem_op && !misaligned;
  assign timeout_hit = (state == S_WAIT) && timer_expired && !mem.mem_done;

  mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (state == S_REQ),
    .enable  (state == S_WAIT),
    .expired (timer_expired)
  );

  // Main FSM plus captured request and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      killed    <= 1'b0;
      data_read <= '0;
      address_o <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid && !flush) begin
            address_o <= in_addr;
            data_read <= '0;
            if (issue) begin
              state   <= S_REQ;
              wr_q    <= in_wr;
              addr_q  <= in_addr;
              wdata_q <= in_wdata;
            end
          end
        end
        S_REQ: begin
          if (mem.mem_stall) begin
            if (flush) state <= S_IDLE;
          end else begin
            state <= S_WAIT;
            if (flush) killed <= 1'b1;
          end
        end
        S_WAIT: begin
          if (flush) killed <= 1'b1;
          if (mem.mem_done) begin
            data_read <= wr_q ? '0 : mem.mem_rdata;
            state     <= S_RESP;
          end else if (timer_expired) begin
            data_read <= '0;
            state     <= S_RESP;
          end
        end
        S_RESP: begin
          killed <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // One-cycle-latency result for non-memory (or rejected) instructions
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass_q      <= 1'b0;
      align_err_q <= 1'b0;
    end else begin
      pass_q      <= (state == S_IDLE) && in_valid && !flush &&
                     (!(in_rd || in_wr) || misaligned);
      align_err_q <= (state == S_IDLE) && mem_op && misaligned;
    end
  end

  assign mem.mem_en    = (state == S_REQ);
  assign mem.mem_wr    = (state == S_REQ) && wr_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;

  assign stall_pipe = (state == S_REQ) || (state == S_WAIT);
  assign out_valid  = pass_q || ((state == S_RESP) && !killed);
  assign err        = timeout_hit || align_err_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed testbench for mem_stage_ctrl with a scoreboard: expected results
// are queued when an instruction is issued and popped by a monitor whenever
// out_valid is seen.
module tb_mem_stage_ctrl;

  typedef struct packed {
    logic [15:0] data;
    logic [15:0] addr;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_rd;
  logic        in_wr;
  logic [15:0] in_addr;
  logic [15:0] in_wdata;
  logic        flush;
  logic        stall_pipe;
  logic        out_valid;
  logic [15:0] data_read;
  logic [15:0] address_o;
  logic        err;

  int   checks = 0;
  int   errors = 0;
  int   en_cnt = 0;
  int   stall_cnt = 0;
  int   err_cnt = 0;
  int   valid_cnt = 0;
  exp_t exp_q[$];

  mem_stage_ctrl_if #(.DW(16), .AW(16)) mem_bus ();

  mem_stage_ctrl #(.DW(16), .AW(16), .TIMEOUT(64)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_rd      (in_rd),
    .in_wr      (in_wr),
    .in_addr    (in_addr),
    .in_wdata   (in_wdata),
    .flush      (flush),
    .mem        (mem_bus),
    .stall_pipe (stall_pipe),
    .out_valid  (out_valid),
    .data_read  (data_read),
    .address_o  (address_o),
    .err        (err)
  );

  // 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Monitor: activity counters and scoreboard pops, sampled on the falling edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (mem_bus.mem_en) en_cnt++;
        if (stall_pipe) stall_cnt++;
        if (err) err_cnt++;
        if (out_valid) begin
          valid_cnt++;
          if (exp_q.size() == 0) begin
            check_output("unexpected out_valid", {16'h0, address_o}, 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            check_output("sb data_read", data_read, e.data);
            check_output("sb address_o", address_o, e.addr);
          end
        end
      end
    end
  end

  // Issue one load/store; done_at/flush_at are WAIT-cycle indices (flush_at<0: none)
  task automatic apply_stimulus(input string tag, input logic rd, input logic wr,
                                input logic [15:0] addr, input logic [15:0] wdata,
                                input int stall_n, input int done_at,
                                input logic [15:0] rdata, input int flush_at,
                                input bit expect_valid, input logic [15:0] exp_data);
    int en0, st0, v0, e0;
    en0 = en_cnt; st0 = stall_cnt; v0 = valid_cnt; e0 = err_cnt;
    in_valid = 1'b1; in_rd = rd; in_wr = wr; in_addr = addr; in_wdata = wdata;
    if (expect_valid) exp_q.push_back('{data: exp_data, addr: addr});
    tick();
    in_valid = 1'b0; in_rd = 1'b0; in_wr = 1'b0;
    for (int i = 0; i <= stall_n; i++) begin
      mem_bus.mem_stall = (i < stall_n);
      check_output({tag, " mem_en"}, mem_bus.mem_en, 1);
      check_output({tag, " mem_addr"}, mem_bus.mem_addr, addr);
      check_output({tag, " mem_wr"}, mem_bus.mem_wr, wr);
      if (wr) check_output({tag, " mem_wdata"}, mem_bus.mem_wdata, wdata);
      tick();
    end
    mem_bus.mem_stall = 1'b0;
    for (int i = 0; i <= done_at; i++) begin
      flush = (i == flush_at);
      mem_bus.mem_done  = (i == done_at);
      mem_bus.mem_rdata = (i == done_at) ? rdata : 16'hDEAD;
      tick();
    end
    flush = 1'b0;
    mem_bus.mem_done = 1'b0;
    tick();
    tick();
    check_output({tag, " mem_en cycles"}, en_cnt - en0, stall_n + 1);
    check_output({tag, " stall cycles"}, stall_cnt - st0, stall_n + 1 + done_at + 1);
    check_output({tag, " out_valid count"}, valid_cnt - v0, expect_valid ? 1 : 0);
    check_output({tag, " err count"}, err_cnt - e0, 0);
  endtask

  initial begin
    int v0, e0, en0, idx;
    $display("[TB] mem_stage_ctrl directed test start");
    rst_n = 1'b0;
    in_valid = 1'b0; in_rd = 1'b0; in_wr = 1'b0;
    in_addr = '0; in_wdata = '0; flush = 1'b0;
    mem_bus.mem_stall = 1'b0; mem_bus.mem_done = 1'b0; mem_bus.mem_rdata = '0;

    #12;
    check_output("reset mem_en", mem_bus.mem_en, 0);
    check_output("reset stall_pipe", stall_pipe, 0);
    check_output("reset out_valid", out_valid, 0);
    check_output("reset err", err, 0);
    check_output("reset data_read", data_read, 0);
    check_output("reset address_o", address_o, 0);
    tick();
    rst_n = 1'b1;
    tick();

    apply_stimulus("load", 1, 0, 16'h0040, 16'h0000, 0, 1, 16'hBEEF, -1, 1, 16'hBEEF);
    apply_stimulus("store", 0, 1, 16'h0010, 16'h1234, 3, 0, 16'hFFFF, -1, 1, 16'h0000);

    // Non-memory instruction: result next cycle, no memory traffic
    en0 = en_cnt; v0 = valid_cnt;
    in_valid = 1'b1; in_addr = 16'h0077;
    exp_q.push_back('{data: 16'h0000, addr: 16'h0077});
    tick();
    in_valid = 1'b0;
    check_output("nonmem out_valid", out_valid, 1);
    check_output("nonmem stall_pipe", stall_pipe, 0);
    tick();
    check_output("nonmem mem_en cycles", en_cnt - en0, 0);
    check_output("nonmem out_valid count", valid_cnt - v0, 1);

    apply_stimulus("flush_wait", 1, 0, 16'h0020, 16'h0000, 0, 2, 16'hAAAA, 1, 0, 16'h0000);
    apply_stimulus("after_flush", 1, 0, 16'h0042, 16'h0000, 1, 0, 16'h5A5A, -1, 1, 16'h5A5A);
    apply_stimulus("rd_and_wr", 1, 1, 16'h0012, 16'h0F0F, 0, 0, 16'hFFFF, -1, 1, 16'h0000);
    apply_stimulus("done_at_limit", 1, 0, 16'h0090, 16'h0000, 0, 63, 16'h1111, -1, 1, 16'h1111);

    // Timeout: no mem_done at all
    e0 = err_cnt; v0 = valid_cnt; idx = -1;
    in_valid = 1'b1; in_rd = 1'b1; in_addr = 16'h0080;
    exp_q.push_back('{data: 16'h0000, addr: 16'h0080});
    tick();
    in_valid = 1'b0; in_rd = 1'b0;
    tick();
    for (int i = 0; i < 100; i++) begin
      if (err) begin
        idx = i;
        break;
      end
      tick();
    end
    check_output("timeout err wait index", idx, 63);
    tick();
    tick();
    check_output("timeout stall_pipe idle", stall_pipe, 0);
    check_output("timeout err count", err_cnt - e0, 1);
    check_output("timeout out_valid count", valid_cnt - v0, 1);

    // Flush in REQ while memory refuses: abort, stray done is ignored
    en0 = en_cnt; v0 = valid_cnt;
    in_valid = 1'b1; in_rd = 1'b1; in_addr = 16'h00A0;
    tick();
    in_valid = 1'b0; in_rd = 1'b0;
    mem_bus.mem_stall = 1'b1; flush = 1'b1;
    tick();
    mem_bus.mem_stall = 1'b0; flush = 1'b0;
    check_output("req abort stall_pipe", stall_pipe, 0);
    check_output("req abort mem_en", mem_bus.mem_en, 0);
    mem_bus.mem_done = 1'b1; mem_bus.mem_rdata = 16'h7777;
    tick();
    mem_bus.mem_done = 1'b0;
    tick();
    check_output("req abort mem_en cycles", en_cnt - en0, 1);
    check_output("req abort out_valid count", valid_cnt - v0, 0);

    // Asynchronous reset while waiting drops the access
    v0 = valid_cnt;
    in_valid = 1'b1; in_rd = 1'b1; in_addr = 16'h00B0;
    tick();
    in_valid = 1'b0; in_rd = 1'b0;
    tick();
    tick();
    check_output("pre-reset stall_pipe", stall_pipe, 1);
    rst_n = 1'b0;
    #1;
    check_output("midreset stall_pipe", stall_pipe, 0);
    check_output("midreset mem_en", mem_bus.mem_en, 0);
    check_output("midreset out_valid", out_valid, 0);
    check_output("midreset address_o", address_o, 0);
    check_output("midreset data_read", data_read, 0);
    tick();
    rst_n = 1'b1;
    mem_bus.mem_done = 1'b1;
    tick();
    mem_bus.mem_done = 1'b0;
    tick();
    check_output("midreset out_valid count", valid_cnt - v0, 0);

`ifdef MEM_ALIGN_CHK_EN
    en0 = en_cnt;
    in_valid = 1'b1; in_rd = 1'b1; in_addr = 16'h0003;
    exp_q.push_back('{data: 16'h0000, addr: 16'h0003});
    tick();
    in_valid = 1'b0; in_rd = 1'b0;
    check_output("align err", err, 1);
    check_output("align mem_en", mem_bus.mem_en, 0);
    check_output("align stall_pipe", stall_pipe, 0);
    check_output("align out_valid", out_valid, 1);
    tick();
    check_output("align err cleared", err, 0);
    check_output("align mem_en cycles", en_cnt - en0, 0);
`else
    apply_stimulus("odd_addr", 1, 0, 16'h0003, 16'h0000, 0, 0, 16'h3333, -1, 1, 16'h3333);
`endif

    tick();
    check_output("scoreboard drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Bound on total run time
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
